// File: rtl/contador_decada_bcd_pkg.sv
// ============================================================================
// Module      : contador_decada_bcd_pkg
// Description : Shared constants and helpers for the BCD decade counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package contador_decada_bcd_pkg;

    localparam int          BCD_LARGURA = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    // Control FSM encoding
    localparam logic [0:0]  PARADO      = 1'b0;
    localparam logic [0:0]  CONTANDO    = 1'b1;

    // Out-of-range load digits are forced to zero so the count stays in 0..9
    function automatic logic [BCD_LARGURA-1:0] saturar_carga(
        input logic [BCD_LARGURA-1:0] v
    );
        return (v > BCD_MAX) ? '0 : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_decada_bcd_digito_bcd.sv
// ============================================================================
// Module      : digito_bcd
// Description : One 0..9 BCD digit with load, up/down step and carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digito_bcd
    import contador_decada_bcd_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   carregar,
    input  logic [BCD_LARGURA-1:0] valor_in,
    input  logic                   passo_in,
    input  logic                   decrementar,
    output logic [BCD_LARGURA-1:0] valor,
    output logic                   passo_out
);

    logic [BCD_LARGURA-1:0] r_valor;
    logic                   w_terminal;

    // Terminal value is where this digit wraps and ripples to the next one
    assign w_terminal = decrementar ? (r_valor == '0) : (r_valor == BCD_MAX);
    assign passo_out  = passo_in & w_terminal;
    assign valor      = r_valor;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valor <= '0;
        end else if (carregar) begin
            r_valor <= saturar_carga(valor_in);
        end else if (passo_in) begin
            if (decrementar) begin
                r_valor <= w_terminal ? BCD_MAX : (r_valor - 4'd1);
            end else begin
                r_valor <= w_terminal ? '0 : (r_valor + 4'd1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/contador_decada_bcd.sv
// ============================================================================
// Module      : contador_decada_bcd
// Description : Multi-digit BCD decade counter with start/stop FSM, prescaler
//               and parallel load. Optional macro DETECTOR_BORDA_EN turns
//               iniciar_parar into a synchronized, edge-detected level input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_decada_bcd
    import contador_decada_bcd_pkg::*;
#(
    parameter int DIGITOS       = 2,
    parameter int DIV_PRESCALER = 50000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar_parar,
    input  logic                     decrementar,
    input  logic                     carregar,
    input  logic [4*DIGITOS-1:0]     valor_carga,
    output logic [4*DIGITOS-1:0]     bcd,
    output logic                     estouro,
    output logic                     contando
);

    localparam int c_LARG_PRE = (DIV_PRESCALER > 1) ? $clog2(DIV_PRESCALER) : 1;
    localparam logic [c_LARG_PRE-1:0] c_PRE_MAX = c_LARG_PRE'(DIV_PRESCALER - 1);

    logic [0:0]            r_estado;
    logic [0:0]            w_estado_prox;
    logic [c_LARG_PRE-1:0] r_pre;
    logic                  w_passo;
    logic                  w_evento;
    logic                  r_estouro;
    logic [DIGITOS:0]      w_cadeia;

`ifdef DETECTOR_BORDA_EN
    logic r_sinc1;
    logic r_sinc2;
    logic r_anterior;
    logic r_evento;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sinc1    <= 1'b0;
            r_sinc2    <= 1'b0;
            r_anterior <= 1'b0;
            r_evento   <= 1'b0;
        end else begin
            r_sinc1    <= iniciar_parar;
            r_sinc2    <= r_sinc1;
            r_anterior <= r_sinc2;
            r_evento   <= r_sinc2 & ~r_anterior;
        end
    end

    assign w_evento = r_evento;
`else
    assign w_evento = iniciar_parar;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= PARADO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        case (r_estado)
            PARADO:   if (w_evento) w_estado_prox = CONTANDO;
            CONTANDO: if (w_evento) w_estado_prox = PARADO;
            default:  w_estado_prox = PARADO;
        endcase
    end

    assign w_passo = (r_estado == CONTANDO) && (r_pre == c_PRE_MAX);

    // Prescaler freezes while stopped so a pause resumes mid-period
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre <= '0;
        end else if (carregar) begin
            r_pre <= '0;
        end else if (r_estado == CONTANDO) begin
            r_pre <= w_passo ? '0 : (r_pre + c_LARG_PRE'(1));
        end
    end

    assign w_cadeia[0] = w_passo;

    generate
        for (genvar i = 0; i < DIGITOS; i++) begin : g_digito
            digito_bcd u_digito (
                .clock       (clock),
                .reset       (reset),
                .carregar    (carregar),
                .valor_in    (valor_carga[4*i +: 4]),
                .passo_in    (w_cadeia[i]),
                .decrementar (decrementar),
                .valor       (bcd[4*i +: 4]),
                .passo_out   (w_cadeia[i+1])
            );
        end
    endgenerate

    // A ripple out of the top digit is exactly the full-range wrap
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estouro <= 1'b0;
        end else begin
            r_estouro <= w_cadeia[DIGITOS] & ~carregar;
        end
    end

    assign estouro  = r_estouro;
    assign contando = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_contador_decada_bcd.sv
// ============================================================================
// Module      : tb_contador_decada_bcd
// Description : Self-checking bench for contador_decada_bcd (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_decada_bcd;

    localparam int DIG = 2;
    localparam int DIV = 4;
    localparam int MODULO = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar_parar;
    logic       decrementar;
    logic       carregar;
    logic [7:0] valor_carga;
    logic [7:0] bcd;
    logic       estouro;
    logic       contando;

    int  m_val;
    int  m_pre;
    bit  m_st;
    bit  m_est;
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clock = ~clock;

    contador_decada_bcd #(
        .DIGITOS       (DIG),
        .DIV_PRESCALER (DIV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar_parar (iniciar_parar),
        .decrementar   (decrementar),
        .carregar      (carregar),
        .valor_carga   (valor_carga),
        .bcd           (bcd),
        .estouro       (estouro),
        .contando      (contando)
    );

    function automatic int digito_carga(input int d);
        return (d > 9) ? 0 : d;
    endfunction

    // Reference: count kept as a plain integer 0..99
    function automatic void modelo();
        bit passo;
        passo = m_st && (m_pre == DIV - 1);
        if (reset) begin
            m_val = 0; m_pre = 0; m_st = 0; m_est = 0;
        end else begin
            m_est = 0;
            if (carregar) begin
                m_val = digito_carga(int'(valor_carga[7:4])) * 10 + digito_carga(int'(valor_carga[3:0]));
                m_pre = 0;
            end else if (passo) begin
                if (!decrementar) begin
                    m_est = (m_val == MODULO - 1);
                    m_val = (m_val + 1) % MODULO;
                end else begin
                    m_est = (m_val == 0);
                    m_val = (m_val + MODULO - 1) % MODULO;
                end
                m_pre = 0;
            end else if (m_st) begin
                m_pre = m_pre + 1;
            end
            if (iniciar_parar) m_st = !m_st;
        end
    endfunction

    function automatic logic [9:0] esperado();
        return {4'(m_val / 10), 4'(m_val % 10), m_est, m_st};
    endfunction

    task automatic tick();
        @(posedge clock);
        modelo();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; iniciar_parar = 1'b0; carregar = 1'b0;
        decrementar = 1'b0; valor_carga = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({bcd, estouro, contando} !== 10'h000)
            $display("FAIL reset_state: got %h required %h", {bcd, estouro, contando}, 10'h000);
        else n_pass++;
    endtask

    task automatic test_start_count();
        iniciar_parar = 1'b1;
        tick();
        iniciar_parar = 1'b0;
        n_checks++;
        if (contando !== 1'b1) $display("FAIL start_contando: got %b required 1", contando);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({bcd, estouro, contando} !== esperado())
                $display("FAIL start_cycle%0d: got %h required %h", i, {bcd, estouro, contando}, esperado());
            else n_pass++;
            if (i == 3 || i == 7) begin
                n_checks++;
                if (bcd !== ((i == 3) ? 8'h01 : 8'h02))
                    $display("FAIL start_step%0d: got %h required %h", i, bcd, (i == 3) ? 8'h01 : 8'h02);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap(input bit baixo);
        int pulsos;
        pulsos = 0;
        decrementar = baixo;
        carregar = 1'b1;
        valor_carga = baixo ? 8'h01 : 8'h98;
        tick();
        carregar = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (estouro === 1'b1) pulsos++;
            n_checks++;
            if ({bcd, estouro, contando} !== esperado())
                $display("FAIL wrap%0d_cycle%0d: got %h required %h", baixo, i, {bcd, estouro, contando}, esperado());
            else n_pass++;
            if (i == 7) begin
                n_checks++;
                if ({bcd, estouro} !== {(baixo ? 8'h99 : 8'h00), 1'b1})
                    $display("FAIL wrap%0d_value: got %h required %h", baixo, {bcd, estouro},
                             {(baixo ? 8'h99 : 8'h00), 1'b1});
                else n_pass++;
            end
        end
        n_checks++;
        if (pulsos != 1) $display("FAIL wrap%0d_pulses: got %0d required 1", baixo, pulsos);
        else n_pass++;
        decrementar = 1'b0;
    endtask

    task automatic test_load();
        bit achou;
        carregar = 1'b1;
        valor_carga = 8'h5C;
        tick();
        carregar = 1'b0;
        n_checks++;
        if (bcd !== 8'h50) $display("FAIL load_invalid: got %h required 50", bcd);
        else n_pass++;
        achou = 0;
        for (int i = 0; i < 2 * DIV && !achou; i++) begin
            if (m_st && m_pre == DIV - 1) achou = 1;
            else tick();
        end
        n_checks++;
        if (!achou) $display("FAIL load_wait_step: got timeout required step");
        else n_pass++;
        carregar = 1'b1;
        valor_carga = 8'h42;
        tick();
        carregar = 1'b0;
        n_checks++;
        if ({bcd, estouro} !== {8'h42, 1'b0})
            $display("FAIL load_vs_step: got %h required %h", {bcd, estouro}, {8'h42, 1'b0});
        else n_pass++;
    endtask

    task automatic test_pause_reset();
        carregar = 1'b1;
        valor_carga = 8'h07;
        tick();
        carregar = 1'b0;
        tick();
        iniciar_parar = 1'b1;
        tick();
        iniciar_parar = 1'b0;
        n_checks++;
        if ({bcd, estouro, contando} !== esperado())
            $display("FAIL pause_stop: got %h required %h", {bcd, estouro, contando}, esperado());
        else n_pass++;
        repeat (20) tick();
        n_checks++;
        if ({bcd, contando} !== {8'h07, 1'b0})
            $display("FAIL pause_hold: got %h required %h", {bcd, contando}, {8'h07, 1'b0});
        else n_pass++;
        iniciar_parar = 1'b1;
        tick();
        iniciar_parar = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bcd !== 8'h08) $display("FAIL pause_resume: got %h required 08", bcd);
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({bcd, estouro, contando} !== 10'h000)
            $display("FAIL reset_midcount: got %h required %h", {bcd, estouro, contando}, 10'h000);
        else n_pass++;
    endtask

    task automatic test_toggle_held();
        iniciar_parar = 1'b1;
        repeat (3) tick();
        iniciar_parar = 1'b0;
        n_checks++;
        if ({contando, m_st} !== 2'b11)
            $display("FAIL toggle_held: got %b required 1 (model %b)", contando, m_st);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom % 64) == 0;
            iniciar_parar = ($urandom % 16) == 0;
            carregar      = ($urandom % 12) == 0;
            decrementar   = ($urandom % 40 < 20);
            valor_carga   = 8'($urandom);
            tick();
            n_checks++;
            if ({bcd, estouro, contando} !== esperado())
                $display("FAIL random_cycle%0d: got %h required %h", i, {bcd, estouro, contando}, esperado());
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        m_val = 0; m_pre = 0; m_st = 0; m_est = 0;
        test_reset();
        test_start_count();
        test_wrap(1'b0);
        test_wrap(1'b1);
        test_load();
        test_pause_reset();
        test_toggle_held();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
